// File: rtl/tick_mon_pkg.sv
// Shared types for the tick period monitor: FSM states and tolerance window math.
package tick_mon_pkg;

  typedef enum logic {SEARCH = 1'b0, MEASURE = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
  } tol_bounds_t;

  // Inclusive window of periods that count as good.
  function automatic tol_bounds_t tol_bounds(input int unsigned exp_period,
                                             input int unsigned tol);
    tol_bounds_t b;
    b.lo = exp_period - tol;
    b.hi = exp_period + tol;
    return b;
  endfunction

endpackage

// File: rtl/sat_interval_counter.sv
// Cycle counter between ticks: loads 1 on a tick, saturates at all-ones,
// and sits at 0 while the monitor is disarmed.
module sat_interval_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tick,
  input  logic             disarm,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= CNT_W'(1);
    end else if (disarm) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tick_period_meter.sv
// Measures tick-to-tick spacing, flags early/late ticks, tracks lock and
// offers each measured period through a one-entry valid/ready holding register.
module tick_period_meter
  import tick_mon_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 1000,
  parameter int TOL        = 2,
  parameter int LOCK_N     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  input  logic             period_ready_i,
  output logic             lock_o,
  output logic             err_early_o,
  output logic             err_late_o,
  output logic             overrun_o,
  output state_e           dbg_state
);

  localparam tol_bounds_t BOUNDS = tol_bounds(EXP_PERIOD, TOL);
  localparam logic [CNT_W-1:0] LO = BOUNDS.lo[CNT_W-1:0];
  localparam logic [CNT_W-1:0] HI = BOUNDS.hi[CNT_W-1:0];
  localparam int LOCK_W = $clog2(LOCK_N + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_N);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic              disarm;
  logic              accept_new;

  assign disarm = (state == SEARCH);

  sat_interval_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_i),
    .tick   (tick_i),
    .disarm (disarm),
    .cnt    (cnt)
  );

  // Handshake: period_o is offered while period_valid_o is high and is taken
  // on any edge where period_valid_o && period_ready_i; a new measurement may
  // load on that same edge, otherwise it is dropped and overrun_o latches.
  assign accept_new = !period_valid_o || period_ready_i;

  assign lock_o    = (lock_cnt == LOCK_MAX);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= SEARCH;
      lock_cnt       <= '0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      err_early_o    <= 1'b0;
      err_late_o     <= 1'b0;
      overrun_o      <= 1'b0;
    end else if (clear_i) begin
      state          <= SEARCH;
      lock_cnt       <= '0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      err_early_o    <= 1'b0;
      err_late_o     <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      err_early_o <= 1'b0;
      err_late_o  <= 1'b0;
      if (period_valid_o && period_ready_i) begin
        period_valid_o <= 1'b0;
      end
      if (state == SEARCH) begin
        if (tick_i) begin
          state <= MEASURE;
        end
      end else if (tick_i) begin
        if (accept_new) begin
          period_o       <= cnt;
          period_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
        if (cnt < LO) begin
          err_early_o <= 1'b1;
          lock_cnt    <= '0;
        end else if (cnt <= HI) begin
          if (lock_cnt != LOCK_MAX) begin
            lock_cnt <= lock_cnt + LOCK_W'(1);
          end
        end else begin
          // Late tick: the late pulse already cleared lock; keep it cleared.
          lock_cnt <= '0;
        end
      end else if (cnt == HI) begin
        err_late_o <= 1'b1;
        lock_cnt   <= '0;
      end
    end
  end

endmodule
